mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: cycles in WAIT before a transaction is aborted (used only with MEM_ARB_TIMEOUT_EN).
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on an aborted transaction.
REQ-003 Port clk, input, 1: single clock; all logic on posedge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Ports if_req in 1, if_address in 32: instruction-fetch request (always a 32-bit read).
REQ-006 Ports if_read_data out 32, if_valid out 1, if_err out 1: fetch completion.
REQ-007 Ports d_req in 1, d_rw in 1 (1=write), d_address in 32, d_write_data in 32, d_size in 2: data request.
REQ-008 Ports d_read_data out 32, d_valid out 1, d_err out 1: data completion.
REQ-009 Ports mc_rw_req out 1, mc_rw out 1, mc_address out 32, mc_write_data out 32, mc_size out 2: downstream memory-controller request.
REQ-010 Ports mc_read_data in 32, mc_data_valid in 1: downstream completion.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT, DONE; encoding is free.
REQ-012 IDLE: if either req is high, grant one requester, latch its address/rw/data/size into mc_* registers, and go to ISSUE next cycle.
REQ-013 Arbitration: single requester wins outright; if both are high, the port not granted last wins (round-robin); last_grant resets to fetch, so the first tie goes to data.
REQ-014 A fetch grant drives mc_rw=0 and mc_size=2'h2; mc_write_data is don't-care.
REQ-015 ISSUE: mc_rw_req high for exactly one cycle, then WAIT.
REQ-016 mc_address, mc_rw, mc_write_data and mc_size shall stay stable from ISSUE until leaving WAIT, because the downstream controller samples rw after acceptance.
REQ-017 WAIT: on mc_data_valid, register mc_read_data into the granted port's read_data, pulse its valid for one cycle in the next cycle, and go to DONE.
REQ-018 DONE: one idle cycle with no mc_rw_req, so the downstream controller can return to its idle state; then IDLE.
REQ-019 Latency: req sampled in IDLE at cycle N gives mc_rw_req at N+1; mc_data_valid at cycle M gives x_valid at M+1; the earliest next grant is at M+2.
REQ-020 Requesters hold req and their payload until their valid pulse; req still high at the valid cycle is treated as a new request.
REQ-021 Requests are evaluated only in IDLE; req changes in other states are ignored.
REQ-022 read_data outputs hold their last value between completions.
REQ-023 mc_data_valid outside WAIT is ignored.

Reset
REQ-024 Assertion of reset at any point, including mid-transaction, forces IDLE, last_grant=fetch, all valid/err/mc_rw_req=0, and all data/address outputs=0; the in-flight transaction is dropped with no valid pulse.

Configuration
REQ-025 With MEM_ARB_TIMEOUT_EN defined, a WAIT cycle counter aborts after TIMEOUT cycles without mc_data_valid: the granted port gets valid=1, err=1, read_data=ERR_DATA, and the FSM goes to DONE.
REQ-026 Without MEM_ARB_TIMEOUT_EN, WAIT persists until mc_data_valid, and if_err and d_err are tied 0; the ports exist in both builds.
REQ-027 Under MEM_ARB_TIMEOUT_EN, if mc_data_valid and timeout occur in the same cycle, mc_data_valid wins and err=0.

Structure
REQ-028 Package mem_arb_pkg holds the state enum, port-ID constants (PORT_IF, PORT_D), the TIMEOUT default and the ERR_DATA default.
REQ-029 One sub-module rr_arb2: a two-input round-robin picker (req[1:0], last_grant -> grant) that is purely combinational; last_grant is registered in mem_arbiter.

Verification
REQ-030 Fetch only: if_req, if_address=32'h20; mc responds at +3 cycles with 32'h00000013 -> mc_rw_req one cycle with mc_size=2, mc_rw=0; if_valid=1 with if_read_data=32'h00000013 one cycle after mc_data_valid.
REQ-031 Tie after reset: both reqs high -> data granted first, fetch second, with a DONE gap cycle between transactions.
REQ-032 Data write: d_rw=1, d_address=32'h100, d_write_data=32'hA5A5A5A5, d_size=2 -> mc_* stable across all WAIT cycles; d_valid pulses once.
REQ-033 Continuous contention for 4 transactions -> grant order D, IF, D, IF.
REQ-034 Reset asserted during WAIT -> all outputs 0 immediately; no valid pulse; after release a new fetch completes normally.
REQ-035 MEM_ARB_TIMEOUT_EN, TIMEOUT=8, mc silent -> d_valid=1, d_err=1, d_read_data=32'hDEADBEEF after 8 WAIT cycles; a second run with mc_data_valid on the 8th cycle -> err=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT  = 64;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Fetches are always full 32-bit word reads.
  localparam logic [1:0] FETCH_SIZE = 2'h2;

  // Width of a counter that must hold 0 .. limit-1.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-input combinational round-robin picker; returns the ID of
//               the winning port given the requests and the previous winner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = PORT_IF;
    case (req_i)
      2'b01:   grant_o = PORT_IF;
      2'b10:   grant_o = PORT_D;
      2'b11:   grant_o = (last_grant_i == PORT_IF) ? PORT_D : PORT_IF;
      default: grant_o = PORT_IF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates instruction-fetch and data requests onto a single
//               memory-controller port. Optional WAIT timeout is enabled by
//               defining MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_address,
  output logic [31:0] if_read_data,
  output logic        if_valid,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  input  logic [1:0]  d_size,
  output logic [31:0] d_read_data,
  output logic        d_valid,
  output logic        d_err,
  output logic        mc_rw_req,
  output logic        mc_rw,
  output logic [31:0] mc_address,
  output logic [31:0] mc_write_data,
  output logic [1:0]  mc_size,
  input  logic [31:0] mc_read_data,
  input  logic        mc_data_valid
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic        mc_rw_q, mc_rw_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_wdata_q, mc_wdata_d;
  logic [1:0]  mc_size_q, mc_size_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic        if_err_q, if_err_d;
  logic        d_err_q, d_err_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic        w_grant;
  logic        w_grant_en;
  logic        w_abort;
  logic        w_complete;
  logic [31:0] w_ret_data;

  rr_arb2 u_rr_arb2 (
    .req_i        ({d_req, if_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (w_grant)
  );

  assign w_grant_en = (state_q == ST_IDLE) && (if_req || d_req);

`ifdef MEM_ARB_TIMEOUT_EN
  // A real completion in the same cycle as the limit takes precedence.
  assign w_abort = (state_q == ST_WAIT) && !mc_data_valid &&
                   (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign w_abort = 1'b0;
`endif

  assign w_complete = (state_q == ST_WAIT) && (mc_data_valid || w_abort);
  assign w_ret_data = w_abort ? ERR_DATA : mc_read_data;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (if_req || d_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (w_complete) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mc_rw_req     = (state_q == ST_ISSUE);
    mc_rw         = mc_rw_q;
    mc_address    = mc_addr_q;
    mc_write_data = mc_wdata_q;
    mc_size       = mc_size_q;
    if_read_data  = if_rdata_q;
    d_read_data   = d_rdata_q;
    if_valid      = if_valid_q;
    d_valid       = d_valid_q;
    if_err        = if_err_q;
    d_err         = d_err_q;
  end

  // Request latch and completion routing
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    mc_rw_d      = mc_rw_q;
    mc_addr_d    = mc_addr_q;
    mc_wdata_d   = mc_wdata_q;
    mc_size_d    = mc_size_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_valid_d   = 1'b0;
    d_valid_d    = 1'b0;
    if_err_d     = 1'b0;
    d_err_d      = 1'b0;
    wait_cnt_d   = wait_cnt_q;

    if (w_grant_en) begin
      last_grant_d = w_grant;
      owner_d      = w_grant;
      if (w_grant == PORT_D) begin
        mc_rw_d    = d_rw;
        mc_addr_d  = d_address;
        mc_wdata_d = d_write_data;
        mc_size_d  = d_size;
      end else begin
        mc_rw_d    = 1'b0;
        mc_addr_d  = if_address;
        mc_wdata_d = '0;
        mc_size_d  = FETCH_SIZE;
      end
    end

    if (state_q == ST_ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    if (w_complete) begin
      if (owner_q == PORT_D) begin
        d_rdata_d = w_ret_data;
        d_valid_d = 1'b1;
        d_err_d   = w_abort;
      end else begin
        if_rdata_d = w_ret_data;
        if_valid_d = 1'b1;
        if_err_d   = w_abort;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= PORT_IF;
      owner_q      <= PORT_IF;
      mc_rw_q      <= 1'b0;
      mc_addr_q    <= '0;
      mc_wdata_q   <= '0;
      mc_size_q    <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_valid_q   <= 1'b0;
      d_valid_q    <= 1'b0;
      if_err_q     <= 1'b0;
      d_err_q      <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      mc_rw_q      <= mc_rw_d;
      mc_addr_q    <= mc_addr_d;
      mc_wdata_q   <= mc_wdata_d;
      mc_size_q    <= mc_size_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_valid_q   <= if_valid_d;
      d_valid_q    <= d_valid_d;
      if_err_q     <= if_err_d;
      d_err_q      <= d_err_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire
